fila_escrita_registradores: RTL and testbench
=============================================

// Module: fila_escrita_registradores
// PURPOSE
//  Write-back queue driving the single write port of the 32x32 register file.
//  Accepts results from the ALU and load unit (valid/ready), drops rd=x0 results, buffers in order, writes one per cycle.
//  Reports pending writes so decode can stall on RAW hazards.
// PARAMETERS
//  PROFUNDIDADE   4   queue entries; power of two, >=2
//  LARGURA_DADOS  32  result width in bits
// PORTS
//  clk                    input  1   system clock, rising edge
//  reset                  input  1   synchronous, active-low (0 = reset at next rising edge)
//  ula_valido             input  1   ALU offers a result
//  ula_rd                 input  5   ALU destination register
//  ula_dados              input  32  ALU result
//  ula_pronto             output 1   ALU result accepted this cycle
//  mem_valido             input  1   load unit offers a result
//  mem_rd                 input  5   load destination register
//  mem_dados              input  32  load data
//  mem_pronto             output 1   load result accepted this cycle
//  porta_livre            input  1   register-file write port available this cycle
//  escrever_registrador   output 1   write strobe to register file
//  registrador_escrita    output 5   write address to register file
//  dados_escrita          output 32  write data to register file
//  consulta_rs1           input  5   decode source register 1
//  consulta_rs2           input  5   decode source register 2
//  pendente1              output 1   consulta_rs1 has a queued write
//  pendente2              output 1   consulta_rs2 has a queued write
//  ocupacao               output clog2(PROFUNDIDADE)+1  valid entries in queue
//  vazia                  output 1   ocupacao == 0
// BEHAVIOUR
//  - Reset (reset==0 at rising edge): pointers/count cleared, all entries invalid; afterwards
//    escrever_registrador=0, registrador_escrita=0, dados_escrita=0, ocupacao=0, vazia=1, pendente1/2=0.
//  - Reset mid-operation discards all queued entries; no write is issued for them.
//  - Acceptance: cheia = (ocupacao==PROFUNDIDADE). At most one push per cycle; load has priority.
//    mem_pronto = !cheia; ula_pronto = !cheia && !mem_valido. Transfer = valido && pronto at rising edge.
//  - rd==0 results: handshake completes (pronto as above) but nothing is enqueued; ocupacao unchanged.
//  - Full: both pronto=0 even if a pop happens in the same cycle (no pass-through).
//  - Drain: escrever_registrador = !vazia && porta_livre; address/data are head-entry fields
//    (0 when vazia). Head pops at the rising edge where escrever_registrador==1.
//  - Latency: result accepted at edge k is on the write port in the cycle after edge k (if head and
//    porta_livre=1) and lands in the register file at edge k+1.
//  - Simultaneous push+pop: ocupacao unchanged; both pointers advance.
//  - Pointers wrap modulo PROFUNDIDADE; ordering strictly FIFO; repeated rd written in order, last wins.
//  - pendente1/2: combinational; 1 iff rs!=0 and any valid queued entry has rd==rs. Entries being
//    accepted this cycle are not included.
//  - Head entry stays visible while porta_livre=0; no data change while stalled.
// TESTING
//  1 Reset: hold reset=0 one edge with queue holding 2 entries -> ocupacao=0, vazia=1, escrever_registrador=0, no writes.
//  2 Single: ula rd=5 data=0xDEADBEEF, porta_livre=1 -> next cycle escrever=1, rd=5, data=0xDEADBEEF; then escrever=0.
//  3 Collision: mem rd=3 0x11 and ula rd=4 0x22 same cycle -> mem_pronto=1, ula_pronto=0; ula accepted
//    next cycle; writes x3=0x11 then x4=0x22 on consecutive cycles.
//  4 x0 drop: ula rd=0 data=0xFFFFFFFF -> ula_pronto=1, ocupacao stays 0, escrever never asserts.
//  5 Full/wrap: porta_livre=0, push 4 entries rd=1..4 -> ocupacao=4, both pronto=0; 5th held;
//    release porta_livre -> writes x1..x4 then x5 in order, no loss or duplication.
//  6 Hazard: queue rd=7 with porta_livre=0, consulta_rs1=7, consulta_rs2=0 -> pendente1=1, pendente2=0;
//    release -> pendente1 falls after the write edge.

Source files
------------

// File: rtl/fila_escrita_registradores.sv
// Write-back queue feeding the single register-file write port: in-order buffer of ALU/load
// results, x0 results dropped, with pending-write lookup so decode can stall on RAW hazards.
module fila_escrita_registradores #(
  parameter int PROFUNDIDADE  = 4,
  parameter int LARGURA_DADOS = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ula_valido,
  input  logic [4:0]                      ula_rd,
  input  logic [LARGURA_DADOS-1:0]        ula_dados,
  output logic                            ula_pronto,
  input  logic                            mem_valido,
  input  logic [4:0]                      mem_rd,
  input  logic [LARGURA_DADOS-1:0]        mem_dados,
  output logic                            mem_pronto,
  input  logic                            porta_livre,
  output logic                            escrever_registrador,
  output logic [4:0]                      registrador_escrita,
  output logic [LARGURA_DADOS-1:0]        dados_escrita,
  input  logic [4:0]                      consulta_rs1,
  input  logic [4:0]                      consulta_rs2,
  output logic                            pendente1,
  output logic                            pendente2,
  output logic [$clog2(PROFUNDIDADE):0]   ocupacao,
  output logic                            vazia
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int CW = PW + 1;

  logic [4:0]               fila_rd    [PROFUNDIDADE];
  logic [LARGURA_DADOS-1:0] fila_dados [PROFUNDIDADE];
  logic [PROFUNDIDADE-1:0]  fila_valida;
  logic [PW-1:0]            ptr_escrita;
  logic [PW-1:0]            ptr_leitura;

  logic                     cheia;
  logic                     aceita_mem;
  logic                     aceita_ula;
  logic                     empilha;
  logic [4:0]               rd_entrada;
  logic [LARGURA_DADOS-1:0] dados_entrada;

  // NOTE: every signal assigned in an always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    cheia         = (ocupacao == CW'(PROFUNDIDADE));
    vazia         = (ocupacao == '0);
    mem_pronto    = !cheia;
    ula_pronto    = !cheia && !mem_valido;
    aceita_mem    = mem_valido && mem_pronto;
    aceita_ula    = ula_valido && ula_pronto;
    rd_entrada    = aceita_mem ? mem_rd : ula_rd;
    dados_entrada = aceita_mem ? mem_dados : ula_dados;
    // x0 results still complete the handshake but never occupy an entry.
    empilha       = (aceita_mem || aceita_ula) && (rd_entrada != 5'd0);

    escrever_registrador = !vazia && porta_livre;
    registrador_escrita  = vazia ? '0 : fila_rd[ptr_leitura];
    dados_escrita        = vazia ? '0 : fila_dados[ptr_leitura];
  end

  // Hazard lookup covers only entries already stored; the one being accepted is not yet visible.
  always_comb begin
    pendente1 = 1'b0;
    pendente2 = 1'b0;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      if (fila_valida[i] && (fila_rd[i] == consulta_rs1)) pendente1 = 1'b1;
      if (fila_valida[i] && (fila_rd[i] == consulta_rs2)) pendente2 = 1'b1;
    end
    pendente1 = pendente1 && (consulta_rs1 != 5'd0);
    pendente2 = pendente2 && (consulta_rs2 != 5'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_escrita <= '0;
      ptr_leitura <= '0;
      ocupacao    <= '0;
      fila_valida <= '0;
    end else begin
      if (escrever_registrador) begin
        fila_valida[ptr_leitura] <= 1'b0;
        ptr_leitura              <= ptr_leitura + PW'(1);
      end
      if (empilha) begin
        fila_valida[ptr_escrita] <= 1'b1;
        ptr_escrita              <= ptr_escrita + PW'(1);
      end
      case ({empilha, escrever_registrador})
        2'b10:   ocupacao <= ocupacao + CW'(1);
        2'b01:   ocupacao <= ocupacao - CW'(1);
        default: ocupacao <= ocupacao;
      endcase
    end
  end

  // NOTE: payload storage has no reset; the valid bits and the count decide what is ever observed.
  always_ff @(posedge clk) begin
    if (empilha) begin
      fila_rd[ptr_escrita]    <= rd_entrada;
      fila_dados[ptr_escrita] <= dados_entrada;
    end
  end

endmodule

// File: tb/tb_fila_escrita_registradores.sv
// Self-checking bench for fila_escrita_registradores: directed table, hand-written corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_fila_escrita_registradores;

  localparam int PROF = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ula_valido, mem_valido, porta_livre;
  logic [4:0]  ula_rd, mem_rd, consulta_rs1, consulta_rs2;
  logic [31:0] ula_dados, mem_dados;
  logic        ula_pronto, mem_pronto, escrever_registrador, pendente1, pendente2, vazia;
  logic [4:0]  registrador_escrita;
  logic [31:0] dados_escrita;
  logic [2:0]  ocupacao;

  fila_escrita_registradores #(.PROFUNDIDADE(PROF), .LARGURA_DADOS(32)) dut (
    .clk(clk), .reset(reset),
    .ula_valido(ula_valido), .ula_rd(ula_rd), .ula_dados(ula_dados), .ula_pronto(ula_pronto),
    .mem_valido(mem_valido), .mem_rd(mem_rd), .mem_dados(mem_dados), .mem_pronto(mem_pronto),
    .porta_livre(porta_livre), .escrever_registrador(escrever_registrador),
    .registrador_escrita(registrador_escrita), .dados_escrita(dados_escrita),
    .consulta_rs1(consulta_rs1), .consulta_rs2(consulta_rs2),
    .pendente1(pendente1), .pendente2(pendente2), .ocupacao(ocupacao), .vazia(vazia)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dados;
  } ent_t;

  typedef struct {
    logic        uv;
    logic [4:0]  urd;
    logic [31:0] ud;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        pl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_up;
    logic        e_mp;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_dados;
    logic [2:0]  e_ocup;
    logic        e_p1;
    logic        e_p2;
  } vec_t;

  ent_t       modelo[$];
  logic [4:0] registro_escritas[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    n_vec++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // Reference: outputs derived directly from the queue contents and current inputs.
  task automatic compare_model();
    logic       cheia, p1, p2;
    logic [4:0] e_rd;
    logic [31:0] e_dados;
    cheia   = (modelo.size() == PROF);
    e_rd    = (modelo.size() > 0) ? modelo[0].rd : 5'd0;
    e_dados = (modelo.size() > 0) ? modelo[0].dados : 32'd0;
    p1 = 1'b0;
    p2 = 1'b0;
    foreach (modelo[i]) begin
      if (modelo[i].rd == consulta_rs1) p1 = 1'b1;
      if (modelo[i].rd == consulta_rs2) p2 = 1'b1;
    end
    check("mem_pronto", mem_pronto, !cheia);
    check("ula_pronto", ula_pronto, !cheia && !mem_valido);
    check("escrever", escrever_registrador, (modelo.size() > 0) && porta_livre);
    check("reg_escrita", registrador_escrita, e_rd);
    check("dados_escrita", dados_escrita, e_dados);
    check("ocupacao", ocupacao, modelo.size());
    check("vazia", vazia, modelo.size() == 0);
    check("pendente1", pendente1, p1 && (consulta_rs1 != 0));
    check("pendente2", pendente2, p2 && (consulta_rs2 != 0));
  endtask

  task automatic model_edge();
    logic cheia, aceito;
    ent_t novo;
    cheia  = (modelo.size() == PROF);
    aceito = 1'b0;
    if (mem_valido && !cheia) begin
      aceito = 1'b1;
      novo   = '{rd: mem_rd, dados: mem_dados};
    end else if (ula_valido && !cheia) begin
      aceito = 1'b1;
      novo   = '{rd: ula_rd, dados: ula_dados};
    end
    if (!reset) begin
      modelo.delete();
    end else begin
      if (modelo.size() > 0 && porta_livre) void'(modelo.pop_front());
      if (aceito && novo.rd != 5'd0) modelo.push_back(novo);
    end
  endtask

  task automatic finish_cycle();
    if (reset && escrever_registrador) registro_escritas.push_back(registrador_escrita);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cycle_model();
    #1;
    compare_model();
    finish_cycle();
  endtask

  task automatic idle();
    ula_valido = 1'b0; mem_valido = 1'b0;
    ula_rd = '0; mem_rd = '0; ula_dados = '0; mem_dados = '0;
  endtask

  vec_t tabela[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tabela[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 5, 0, 1, 1, 0, 0, 0,            0, 0, 0};
    tabela[1] = '{0, 0, 0,            0, 0, 0,      1, 5, 0, 1, 1, 1, 5, 32'hDEADBEEF, 1, 1, 0};
    tabela[2] = '{1, 4, 32'h22,       1, 3, 32'h11, 1, 3, 4, 0, 1, 0, 0, 0,            0, 0, 0};
    tabela[3] = '{1, 4, 32'h22,       0, 0, 0,      1, 3, 4, 1, 1, 1, 3, 32'h11,       1, 1, 0};
    tabela[4] = '{0, 0, 0,            0, 0, 0,      1, 3, 4, 1, 1, 1, 4, 32'h22,       1, 0, 1};
    tabela[5] = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,      1, 0, 0, 1, 1, 0, 0, 0,            0, 0, 0};
    tabela[6] = '{0, 0, 0,            0, 0, 0,      1, 0, 0, 1, 1, 0, 0, 0,            0, 0, 0};

    reset = 1'b0; idle(); porta_livre = 1'b1; consulta_rs1 = 5'd5; consulta_rs2 = 5'd0;
    repeat (2) @(negedge clk);
    modelo.delete();
    reset = 1'b1;
    #1;
    check("rst_escrever", escrever_registrador, 1'b0);
    check("rst_reg", registrador_escrita, 5'd0);
    check("rst_dados", dados_escrita, 32'd0);
    check("rst_ocupacao", ocupacao, 3'd0);
    check("rst_vazia", vazia, 1'b1);
    check("rst_pendente1", pendente1, 1'b0);
    check("rst_pendente2", pendente2, 1'b0);
    @(negedge clk);

    // Directed table: single write, load/ALU collision, x0 drop.
    for (int i = 0; i < 7; i++) begin
      ula_valido = tabela[i].uv; ula_rd = tabela[i].urd; ula_dados = tabela[i].ud;
      mem_valido = tabela[i].mv; mem_rd = tabela[i].mrd; mem_dados = tabela[i].md;
      porta_livre = tabela[i].pl; consulta_rs1 = tabela[i].rs1; consulta_rs2 = tabela[i].rs2;
      #1;
      check($sformatf("tab%0d_ula_pronto", i), ula_pronto, tabela[i].e_up);
      check($sformatf("tab%0d_mem_pronto", i), mem_pronto, tabela[i].e_mp);
      check($sformatf("tab%0d_escrever", i), escrever_registrador, tabela[i].e_wr);
      check($sformatf("tab%0d_reg", i), registrador_escrita, tabela[i].e_rd);
      check($sformatf("tab%0d_dados", i), dados_escrita, tabela[i].e_dados);
      check($sformatf("tab%0d_ocupacao", i), ocupacao, tabela[i].e_ocup);
      check($sformatf("tab%0d_pendente1", i), pendente1, tabela[i].e_p1);
      check($sformatf("tab%0d_pendente2", i), pendente2, tabela[i].e_p2);
      finish_cycle();
    end

    // Reset with two entries queued: everything discarded, nothing written afterwards.
    idle(); porta_livre = 1'b0; consulta_rs1 = 5'd9; consulta_rs2 = 5'd10;
    ula_valido = 1'b1; ula_rd = 5'd9;  ula_dados = 32'h99; cycle_model();
    ula_rd = 5'd10; ula_dados = 32'hAA; cycle_model();
    idle();
    #1;
    check("pre_rst_ocupacao", ocupacao, 3'd2);
    reset = 1'b0;
    finish_cycle();
    reset = 1'b1; porta_livre = 1'b1;
    registro_escritas.delete();
    #1;
    check("midrst_ocupacao", ocupacao, 3'd0);
    check("midrst_vazia", vazia, 1'b1);
    check("midrst_escrever", escrever_registrador, 1'b0);
    check("midrst_pendente1", pendente1, 1'b0);
    finish_cycle();
    repeat (3) cycle_model();
    check("midrst_no_writes", registro_escritas.size(), 0);

    // Fill while the port is stalled, hold a fifth result, then drain in order.
    registro_escritas.delete();
    porta_livre = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      ula_valido = 1'b1; ula_rd = 5'(r); ula_dados = 32'h100 * r;
      cycle_model();
    end
    ula_rd = 5'd5; ula_dados = 32'h500;
    #1;
    check("cheia_ocupacao", ocupacao, 3'd4);
    check("cheia_ula_pronto", ula_pronto, 1'b0);
    check("cheia_mem_pronto", mem_pronto, 1'b0);
    check("cheia_cabeca_dados", dados_escrita, 32'h100);
    finish_cycle();
    porta_livre = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic aceito;
      #1;
      compare_model();
      aceito = ula_pronto;
      finish_cycle();
      if (aceito) break;
    end
    idle();
    repeat (6) cycle_model();
    check("ordem_qtd", registro_escritas.size(), 5);
    for (int k = 0; k < 5 && k < registro_escritas.size(); k++)
      check($sformatf("ordem_%0d", k), registro_escritas[k], 5'(k + 1));

    // RAW hazard visibility across a stalled and then released write.
    porta_livre = 1'b0; consulta_rs1 = 5'd7; consulta_rs2 = 5'd0;
    ula_valido = 1'b1; ula_rd = 5'd7; ula_dados = 32'h77;
    #1;
    check("hz_antes_aceite", pendente1, 1'b0);
    finish_cycle();
    idle();
    #1;
    check("hz_pendente1", pendente1, 1'b1);
    check("hz_pendente2", pendente2, 1'b0);
    compare_model();
    finish_cycle();
    porta_livre = 1'b1;
    #1;
    check("hz_durante_escrita", pendente1, 1'b1);
    finish_cycle();
    #1;
    check("hz_depois", pendente1, 1'b0);
    finish_cycle();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 79) != 0);
      porta_livre  = ($urandom_range(0, 9) < 6);
      ula_valido   = $urandom_range(0, 1);
      mem_valido   = ($urandom_range(0, 3) == 0);
      ula_rd       = 5'($urandom_range(0, 7));
      mem_rd       = 5'($urandom_range(0, 7));
      ula_dados    = $urandom;
      mem_dados    = $urandom;
      consulta_rs1 = 5'($urandom_range(0, 7));
      consulta_rs2 = 5'($urandom_range(0, 7));
      cycle_model();
    end
    reset = 1'b1; idle(); porta_livre = 1'b1;
    repeat (6) cycle_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
